// File: rtl/mib_slave_endpoint.sv
`default_nettype none
// ============================================================================
//  Module      : mib_slave_endpoint
//  Description : MIB bus responder. Collects a 32-bit address over two AD
//                phases, and on a window hit runs one req/ack access on the
//                local register port, returning the MIB ack (plus read data).
//                Optional macro MIB_SLAVE_ERR_CNT_EN builds a saturating
//                16-bit local-timeout counter on o_err_cnt; otherwise it is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mib_slave_endpoint #(
  parameter logic [31:0] P_BASE_ADDR          = 32'h0001_0000,
  parameter int          P_ADDR_SPAN_BITS     = 12,
  parameter int          P_LOCAL_TIMEOUT_CLKS = 24
) (
  input  logic                        i_sysclk,
  input  logic                        i_srst,
  input  logic                        i_mib_start,
  input  logic                        i_mib_rd_wr_n,
  input  logic [15:0]                 i_mib_ad,
  output logic [15:0]                 o_mib_ad,
  output logic                        o_mib_ad_high_z,
  output logic                        o_mib_slave_ack,
  output logic                        o_reg_req,
  output logic                        o_reg_rd_wr_n,
  output logic [P_ADDR_SPAN_BITS-1:0] o_reg_addr,
  output logic [15:0]                 o_reg_wdata,
  input  logic                        i_reg_ack,
  input  logic [15:0]                 i_reg_rdata,
  output logic [15:0]                 o_err_cnt
);

  localparam int C_TMO_W = $clog2(P_LOCAL_TIMEOUT_CLKS + 1);
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(P_LOCAL_TIMEOUT_CLKS - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ADDR_LO    = 3'd1;
  localparam logic [2:0] S_WR_DATA    = 3'd2;
  localparam logic [2:0] S_LOCAL_WAIT = 3'd3;
  localparam logic [2:0] S_ACK        = 3'd4;

  logic [2:0]                  r_state;
  logic [2:0]                  w_state_nxt;
  logic [15:0]                 r_addr_hi;
  logic                        r_rd_wr_n;
  logic [P_ADDR_SPAN_BITS-1:0] r_reg_addr;
  logic [15:0]                 r_reg_wdata;
  logic [15:0]                 r_rdata;
  logic [C_TMO_W-1:0]          r_tmo_cnt;
  logic [31:0]                 w_addr;
  logic                        w_hit;
  logic                        w_tmo;
  logic                        w_rd_drive;

  // Second address phase completes the 32-bit address directly from the bus.
  assign w_addr = {r_addr_hi, i_mib_ad};
  assign w_hit  = (w_addr[31:P_ADDR_SPAN_BITS] == P_BASE_ADDR[31:P_ADDR_SPAN_BITS]);
  // Abort on the clock that would make req high for one clock too many; an
  // ack arriving on that same clock still wins.
  assign w_tmo  = (r_state == S_LOCAL_WAIT) && !i_reg_ack && (r_tmo_cnt == C_TMO_LAST);

  // State register
  always_ff @(posedge i_sysclk or posedge i_srst) begin
    if (i_srst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; starts outside IDLE are ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (i_mib_start) w_state_nxt = S_ADDR_LO;
      S_ADDR_LO:    w_state_nxt = !w_hit ? S_IDLE : (r_rd_wr_n ? S_LOCAL_WAIT : S_WR_DATA);
      S_WR_DATA:    w_state_nxt = S_LOCAL_WAIT;
      S_LOCAL_WAIT: begin
        if (i_reg_ack)  w_state_nxt = S_ACK;
        else if (w_tmo) w_state_nxt = S_IDLE;
      end
      S_ACK:        w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // Address/data capture and local-timeout counting
  always_ff @(posedge i_sysclk or posedge i_srst) begin
    if (i_srst) begin
      r_addr_hi   <= '0;
      r_rd_wr_n   <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_rdata     <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE && i_mib_start) begin
        r_addr_hi <= i_mib_ad;
        r_rd_wr_n <= i_mib_rd_wr_n;
      end
      if (r_state == S_ADDR_LO && w_hit) begin
        r_reg_addr <= w_addr[P_ADDR_SPAN_BITS-1:0];
      end
      if (r_state == S_WR_DATA) begin
        r_reg_wdata <= i_mib_ad;
      end
      if (r_state == S_LOCAL_WAIT && i_reg_ack && r_rd_wr_n) begin
        r_rdata <= i_reg_rdata;
      end
      // Counter sits at zero outside LOCAL_WAIT so each request starts fresh.
      if (r_state == S_LOCAL_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

`ifdef MIB_SLAVE_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  // Saturating count of local timeouts, cleared only by reset
  always_ff @(posedge i_sysclk or posedge i_srst) begin
    if (i_srst) begin
      r_err_cnt <= '0;
    end else if (w_tmo && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = '0;
`endif

  // Outputs decoded from state so an async reset clears them immediately
  always_comb begin
    w_rd_drive      = (r_state == S_ACK) && r_rd_wr_n;
    o_reg_req       = (r_state == S_LOCAL_WAIT);
    o_mib_slave_ack = (r_state == S_ACK);
    o_mib_ad_high_z = !w_rd_drive;
    o_mib_ad        = w_rd_drive ? r_rdata : 16'h0000;
    o_reg_rd_wr_n   = r_rd_wr_n;
    o_reg_addr      = r_reg_addr;
    o_reg_wdata     = r_reg_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_mib_slave_endpoint.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mib_slave_endpoint
//  Description : Self-checking bench for mib_slave_endpoint: cycle vector
//                table plus timeout and async-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mib_slave_endpoint;

  logic        r_clk;
  logic        r_rst;
  logic        r_start;
  logic        r_rd;
  logic [15:0] r_ad;
  logic        r_rack;
  logic [15:0] r_rdata;
  logic [15:0] w_mib_ad;
  logic        w_hz;
  logic        w_ack;
  logic        w_req;
  logic        w_rdwr;
  logic [11:0] w_addr;
  logic [15:0] w_wdata;
  logic [15:0] w_err;

  int n_chk = 0;
  int n_err = 0;

  mib_slave_endpoint dut (
    .i_sysclk        (r_clk),
    .i_srst          (r_rst),
    .i_mib_start     (r_start),
    .i_mib_rd_wr_n   (r_rd),
    .i_mib_ad        (r_ad),
    .o_mib_ad        (w_mib_ad),
    .o_mib_ad_high_z (w_hz),
    .o_mib_slave_ack (w_ack),
    .o_reg_req       (w_req),
    .o_reg_rd_wr_n   (w_rdwr),
    .o_reg_addr      (w_addr),
    .o_reg_wdata     (w_wdata),
    .i_reg_ack       (r_rack),
    .i_reg_rdata     (r_rdata),
    .o_err_cnt       (w_err)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  typedef struct {
    logic        start;
    logic        rd;
    logic [15:0] ad;
    logic        rack;
    logic [15:0] rdata;
    logic        e_req;
    logic        e_ack;
    logic        e_hz;
    logic [15:0] e_ad;
    logic        chk_data;
    logic [11:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_rdwr;
  } vec_t;

  function automatic vec_t mk(logic s, logic r, logic [15:0] ad, logic ra, logic [15:0] rd,
                              logic q, logic a, logic z, logic [15:0] ea, logic cd,
                              logic [11:0] addr, logic [15:0] wd, logic rw);
    vec_t v;
    v.start = s; v.rd = r; v.ad = ad; v.rack = ra; v.rdata = rd;
    v.e_req = q; v.e_ack = a; v.e_hz = z; v.e_ad = ea; v.chk_data = cd;
    v.e_addr = addr; v.e_wdata = wd; v.e_rdwr = rw;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [15:0] ad,
                       input logic ra, input logic [15:0] rd);
    r_start = s; r_rd = r; r_ad = ad; r_rack = ra; r_rdata = rd;
  endtask

  // Full read transaction with ack on the second req clock; checks the ack cycle
  task automatic read_txn(input string nm, input logic [15:0] lo, input logic [15:0] data);
    drive(1, 1, 16'h0001, 0, 0); tick();
    drive(0, 0, lo, 0, 0);       tick();
    check({nm, ".req"}, w_req, 1);
    drive(0, 0, 0, 0, 0);        tick();
    drive(0, 0, 0, 1, data);     tick();
    check({nm, ".ack"}, w_ack, 1);
    check({nm, ".hz"},  w_hz, 0);
    check({nm, ".ad"},  w_mib_ad, data);
    check({nm, ".addr"}, w_addr, lo[11:0]);
    drive(0, 0, 0, 0, 0);        tick();
    check({nm, ".ack_end"}, w_ack, 0);
    check({nm, ".hz_end"},  w_hz, 1);
  endtask

  vec_t vt[26];
  logic [15:0] exp_err;

  initial begin
    // write hit, ack two clocks after req
    vt[0]  = mk(1,0,16'h0001,0,0,      0,0,1,0,1,12'h000,16'h0000,0);
    vt[1]  = mk(0,0,16'h0234,0,0,      0,0,1,0,1,12'h234,16'h0000,0);
    vt[2]  = mk(0,0,16'hBEEF,0,0,      1,0,1,0,1,12'h234,16'hBEEF,0);
    vt[3]  = mk(0,0,16'h0000,0,0,      1,0,1,0,1,12'h234,16'hBEEF,0);
    vt[4]  = mk(0,0,16'h0000,0,0,      1,0,1,0,1,12'h234,16'hBEEF,0);
    vt[5]  = mk(0,0,16'h0000,1,0,      0,1,1,0,1,12'h234,16'hBEEF,0);
    vt[6]  = mk(0,0,16'h0000,0,0,      0,0,1,0,1,12'h234,16'hBEEF,0);
    // read hit
    vt[7]  = mk(1,1,16'h0001,0,0,      0,0,1,0,1,12'h234,16'hBEEF,1);
    vt[8]  = mk(0,0,16'h0010,0,0,      1,0,1,0,1,12'h010,16'hBEEF,1);
    vt[9]  = mk(0,0,16'h0000,0,0,      1,0,1,0,1,12'h010,16'hBEEF,1);
    vt[10] = mk(0,0,16'h0000,1,16'hA5A5,0,1,0,16'hA5A5,1,12'h010,16'hBEEF,1);
    vt[11] = mk(0,0,16'h0000,0,0,      0,0,1,0,1,12'h010,16'hBEEF,1);
    // miss on upper half, stray local ack while idle
    vt[12] = mk(1,1,16'h0002,0,0,      0,0,1,0,0,12'h000,16'h0000,1);
    vt[13] = mk(0,0,16'h0010,0,0,      0,0,1,0,0,12'h000,16'h0000,1);
    vt[14] = mk(0,0,16'h0000,1,0,      0,0,1,0,0,12'h000,16'h0000,1);
    vt[15] = mk(0,0,16'h0000,0,0,      0,0,1,0,0,12'h000,16'h0000,1);
    // miss just above the window
    vt[16] = mk(1,0,16'h0001,0,0,      0,0,1,0,0,12'h000,16'h0000,0);
    vt[17] = mk(0,0,16'h1000,0,0,      0,0,1,0,0,12'h000,16'h0000,0);
    vt[18] = mk(0,0,16'h1234,0,0,      0,0,1,0,0,12'h000,16'h0000,0);
    // top-of-window write with a start ignored during LOCAL_WAIT
    vt[19] = mk(1,0,16'h0001,0,0,      0,0,1,0,0,12'h000,16'h0000,0);
    vt[20] = mk(0,0,16'h0FFF,0,0,      0,0,1,0,1,12'hFFF,16'hBEEF,0);
    vt[21] = mk(0,0,16'hCAFE,0,0,      1,0,1,0,1,12'hFFF,16'hCAFE,0);
    vt[22] = mk(1,1,16'h0001,0,0,      1,0,1,0,1,12'hFFF,16'hCAFE,0);
    vt[23] = mk(0,0,16'h0555,0,0,      1,0,1,0,1,12'hFFF,16'hCAFE,0);
    vt[24] = mk(0,0,16'h1111,1,0,      0,1,1,0,1,12'hFFF,16'hCAFE,0);
    vt[25] = mk(0,0,16'h0000,0,0,      0,0,1,0,1,12'hFFF,16'hCAFE,0);

`ifdef MIB_SLAVE_ERR_CNT_EN
    exp_err = 16'd1;
`else
    exp_err = 16'd0;
`endif

    r_rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    check("rst.req",   w_req, 0);
    check("rst.ack",   w_ack, 0);
    check("rst.hz",    w_hz, 1);
    check("rst.ad",    w_mib_ad, 0);
    check("rst.addr",  w_addr, 0);
    check("rst.wdata", w_wdata, 0);
    check("rst.rdwr",  w_rdwr, 0);
    check("rst.err",   w_err, 0);
    r_rst = 1'b0;
    tick();

    for (int i = 0; i < 26; i++) begin
      drive(vt[i].start, vt[i].rd, vt[i].ad, vt[i].rack, vt[i].rdata);
      tick();
      check($sformatf("v%0d.req", i), w_req, vt[i].e_req);
      check($sformatf("v%0d.ack", i), w_ack, vt[i].e_ack);
      check($sformatf("v%0d.hz", i),  w_hz,  vt[i].e_hz);
      check($sformatf("v%0d.ad", i),  w_mib_ad, vt[i].e_ad);
      check($sformatf("v%0d.rdwr", i), w_rdwr, vt[i].e_rdwr);
      if (vt[i].chk_data) begin
        check($sformatf("v%0d.addr", i),  w_addr, vt[i].e_addr);
        check($sformatf("v%0d.wdata", i), w_wdata, vt[i].e_wdata);
      end
    end
    check("vec.err", w_err, 0);

    // Local timeout: req must stay high for exactly 24 sampled clocks
    begin
      int hi;
      logic bad;
      hi = 0;
      bad = 1'b0;
      drive(1, 1, 16'h0001, 0, 0); tick();
      drive(0, 0, 16'h0020, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      if (w_req) hi = 1;
      for (int k = 0; k < 60 && w_req; k++) begin
        tick();
        if (w_ack || !w_hz) bad = 1'b1;
        if (w_req) hi++;
      end
      check("tmo.req_clks", hi, 24);
      check("tmo.no_ack", bad, 0);
      check("tmo.err", w_err, exp_err);
      tick();
      check("tmo.idle_ack", w_ack, 0);
    end
    read_txn("after_tmo", 16'h0030, 16'h1357);

    // Async reset in LOCAL_WAIT clears outputs without a clock edge
    drive(1, 0, 16'h0001, 0, 0); tick();
    drive(0, 0, 16'h0040, 0, 0); tick();
    drive(0, 0, 16'h1111, 0, 0); tick();
    drive(0, 0, 0, 0, 0);        tick();
    check("ar.pre_req", w_req, 1);
    #2 r_rst = 1'b1;
    #1;
    check("ar.req",   w_req, 0);
    check("ar.ack",   w_ack, 0);
    check("ar.hz",    w_hz, 1);
    check("ar.addr",  w_addr, 0);
    check("ar.wdata", w_wdata, 0);
    check("ar.err",   w_err, 0);
    r_rst = 1'b0;
    tick();
    read_txn("after_rst", 16'h0050, 16'h2468);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
